fetch_unit: RTL

Instruction fetch stage for the MIPS core: it owns the program counter, fetches each instruction from instruction memory over a request/acknowledge handshake, and presents it to the datapath and control unit. After the datapath accepts the instruction, the block computes the next PC from the control unit's next-PC selection and starts the next fetch. It is the stage directly upstream of the datapath/control pair in the `mips` top.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_if.sv | 28 ++
 rtl/npc_calc.sv | 50 +++++
 rtl/fetch_unit.sv | 116 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// No logic; next-PC select encodings, FSM state enum, reset PC.
// FETCH_ADDR_CHECK_EN adds the ERR state to the enum.
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] FETCH_ADDR_LO  = 32'h0000_3000;
    localparam logic [31:0] FETCH_ADDR_HI  = 32'h0000_6FFC;

    localparam logic [2:0] NPC_PC4 = 3'd0;
    localparam logic [2:0] NPC_BR  = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

`ifdef FETCH_ADDR_CHECK_EN
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} fetch_state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_t;
`endif

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch stage's memory and datapath-facing signals.
// No logic; master = fetch unit, slave = memory + datapath/control side.
// Request held until ack; instruction held until instr_ready.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  npc_op;
    logic        cmp_true;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        addr_err;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, pc_plus8, addr_err,
        input  imem_ack, imem_rdata, instr_ready, npc_op, cmp_true, rs_data
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus8, addr_err,
        output imem_ack, imem_rdata, instr_ready, npc_op, cmp_true, rs_data
    );
endinterface

// File: rtl/npc_calc.sv
// Next-PC computation: PC+4, branch, jump, jr, plus legality check.
// Purely combinational, zero latency.
// No flow control. FETCH_ADDR_CHECK_EN enables alignment/range checks.
module npc_calc
    import fetch_pkg::*;
#(
    parameter logic [31:0] ADDR_LO = FETCH_ADDR_LO,
    parameter logic [31:0] ADDR_HI = FETCH_ADDR_HI
) (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [2:0]  npc_op,
    input  logic        cmp_true,
    input  logic [31:0] rs_data,
    output logic [31:0] npc,
    output logic        npc_illegal
);
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] raw_npc;

    // A misaligned or inverted window would make every fetch illegal.
    if (ADDR_LO[1:0] != 2'b00 || ADDR_HI < ADDR_LO) begin : g_bad_window
        $error("npc_calc: ADDR_LO must be word aligned and not above ADDR_HI");
    end

    assign pc4    = pc + 32'd4;
    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Select the raw target; unused encodings 4-7 fall back to PC+4.
    always_comb begin
        raw_npc = pc4;
        case (npc_op)
            NPC_BR:  raw_npc = cmp_true ? (pc4 + br_off) : pc4;
            NPC_J:   raw_npc = {pc[31:28], instr[25:0], 2'b00};
            NPC_JR:  raw_npc = rs_data;
            default: raw_npc = pc4;
        endcase
    end

`ifdef FETCH_ADDR_CHECK_EN
    assign npc         = raw_npc;
    assign npc_illegal = (raw_npc[1:0] != 2'b00) || (raw_npc < ADDR_LO) || (raw_npc > ADDR_HI);
`else
    // Without checking, a misaligned target is silently word-aligned.
    assign npc         = raw_npc & 32'hFFFF_FFFC;
    assign npc_illegal = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC, fetches over req/ack, hands instr to datapath.
// Latency: ack in cycle N -> instr_valid in N+1; instr_ready in M -> new pc + req in M+1.
// Backpressure: req held until ack; instr/pc held until instr_ready. Option: FETCH_ADDR_CHECK_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter logic [31:0] ADDR_LO  = FETCH_ADDR_LO,
    parameter logic [31:0] ADDR_HI  = FETCH_ADDR_HI
) (
    input  logic    clk,
    input  logic    reset,
    fetch_if.master fif
);
    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         req_q;
    logic         vld_q;
    logic [31:0]  npc;
`ifdef FETCH_ADDR_CHECK_EN
    logic         npc_illegal;
    logic         err_q;
`endif

    npc_calc #(
        .ADDR_LO (ADDR_LO),
        .ADDR_HI (ADDR_HI)
    ) u_npc_calc (
        .pc          (pc_q),
        .instr       (instr_q),
        .npc_op      (fif.npc_op),
        .cmp_true    (fif.cmp_true),
        .rs_data     (fif.rs_data),
        .npc         (npc),
`ifdef FETCH_ADDR_CHECK_EN
        .npc_illegal (npc_illegal)
`else
        .npc_illegal ()
`endif
    );

    // Next state, next pc and instruction capture.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (fif.imem_ack) begin
                    instr_d = fif.imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (fif.instr_ready) begin
`ifdef FETCH_ADDR_CHECK_EN
                    if (npc_illegal) begin
                        state_d = ERR;
                    end else begin
                        pc_d    = npc;
                        state_d = FETCH;
                    end
`else
                    pc_d    = npc;
                    state_d = FETCH;
`endif
                end
            end
`ifdef FETCH_ADDR_CHECK_EN
            ERR: state_d = ERR;
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, pc, instruction and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= (state_d == FETCH);
            vld_q   <= (state_d == HOLD);
        end
    end

`ifdef FETCH_ADDR_CHECK_EN
    // Sticky error flag; only reset clears it since ERR has no exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_d == ERR);
        end
    end
    assign fif.addr_err = err_q;
`else
    assign fif.addr_err = 1'b0;
`endif

    assign fif.imem_req    = req_q;
    assign fif.imem_addr   = pc_q;
    assign fif.instr       = instr_q;
    assign fif.instr_valid = vld_q;
    assign fif.pc          = pc_q;
    assign fif.pc_plus8    = pc_q + 32'd8;

endmodule
